// File: rtl/m_div_ctrl.sv
// Sequencing controller for the iterative restoring divider (DIV/DIVU/REM/REMU).
// Drives the datapath R/D/Z mux selects and applies sign, divide-by-zero and overflow rules.
`ifndef MUX_R_LENGTH
`define MUX_R_LENGTH 2
`endif
`ifndef MUX_D_LENGTH
`define MUX_D_LENGTH 2
`endif
`ifndef MUX_Z_LENGTH
`define MUX_Z_LENGTH 2
`endif
`ifndef MUX_R_KEEP
`define MUX_R_KEEP     2'd0
`define MUX_R_A        2'd1
`define MUX_R_A_NEG    2'd2
`define MUX_R_SUB_KEEP 2'd3
`endif
`ifndef MUX_D_KEEP
`define MUX_D_KEEP  2'd0
`define MUX_D_B     2'd1
`define MUX_D_B_NEG 2'd2
`define MUX_D_SHR   2'd3
`endif
`ifndef MUX_Z_KEEP
`define MUX_Z_KEEP    2'd0
`define MUX_Z_ZERO    2'd1
`define MUX_Z_SHL_ADD 2'd2
`endif

module m_div_ctrl #(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     start,
  input  logic [1:0]               op,
  input  logic [XLEN-1:0]          rs1,
  input  logic [XLEN-1:0]          rs2,
  input  logic [XLEN-1:0]          R,
  input  logic [XLEN-1:0]          Z,
  output logic [`MUX_R_LENGTH-1:0] mux_R,
  output logic [`MUX_D_LENGTH-1:0] mux_D,
  output logic [`MUX_Z_LENGTH-1:0] mux_Z,
  output logic                     busy,
  output logic                     done,
  output logic [XLEN-1:0]          result
);

  // state | meaning
  // IDLE  | waiting for start; special cases answered here directly
  // LOAD  | datapath loads |dividend|, |divisor|, clears quotient
  // ITER  | one restoring-division step per cycle, ITERS cycles
  // FIN   | sign-correct and register the result, pulse done
  typedef enum logic [1:0] {IDLE, LOAD, ITER, FIN} state_t;

  localparam int CW = $clog2(ITERS);
  localparam logic [CW-1:0]   LAST    = CW'(ITERS - 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic            nega_q, nega_d, negb_q, negb_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic [XLEN-1:0] result_q, result_d;

  logic div_zero, ovf;
  assign div_zero = (rs2 == '0);
  assign ovf      = ~op[0] && (rs1 == INT_MIN) && (rs2 == '1);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      nega_q   <= 1'b0;
      negb_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      nega_q   <= nega_d;
      negb_q   <= negb_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && !div_zero && !ovf) state_d = LOAD;
      LOAD:    state_d = ITER;
      ITER:    if (cnt_q == LAST) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    op_d     = op_q;
    nega_d   = nega_q;
    negb_d   = negb_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (div_zero) begin
            result_d = op[1] ? rs1 : '1;
            done_d   = 1'b1;
          end else if (ovf) begin
            result_d = op[1] ? '0 : INT_MIN;
            done_d   = 1'b1;
          end else begin
            busy_d = 1'b1;
            op_d   = op;
            nega_d = ~op[0] & rs1[XLEN-1];
            negb_d = ~op[0] & rs2[XLEN-1];
          end
        end
      end
      LOAD: cnt_d = '0;
      ITER: cnt_d = cnt_q + 1'b1;
      FIN: begin
        case (op_q)
          OP_DIV:  result_d = (nega_q ^ negb_q) ? -Z : Z;
          OP_DIVU: result_d = Z;
          OP_REM:  result_d = nega_q ? -R : R;
          default: result_d = R;
        endcase
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    mux_R = `MUX_R_KEEP;
    mux_D = `MUX_D_KEEP;
    mux_Z = `MUX_Z_KEEP;
    case (state_q)
      LOAD: begin
        mux_R = nega_q ? `MUX_R_A_NEG : `MUX_R_A;
        mux_D = negb_q ? `MUX_D_B_NEG : `MUX_D_B;
        mux_Z = `MUX_Z_ZERO;
      end
      ITER: begin
        mux_R = `MUX_R_SUB_KEEP;
        mux_D = `MUX_D_SHR;
        mux_Z = `MUX_Z_SHL_ADD;
      end
      default: ;
    endcase
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_m_div_ctrl.sv
// Bench for m_div_ctrl: behavioural restoring-divider datapath plus a scoreboard of
// reference RISC-V results and expected done cycles.
module tb_m_div_ctrl;

  localparam logic [1:0] R_KEEP = 2'd0, R_A = 2'd1, R_A_NEG = 2'd2, R_SUB = 2'd3;
  localparam logic [1:0] D_KEEP = 2'd0, D_B = 2'd1, D_B_NEG = 2'd2, D_SHR = 2'd3;
  localparam logic [1:0] Z_KEEP = 2'd0, Z_ZERO = 2'd1, Z_SHL = 2'd2;
  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic [1:0]  mux_R, mux_D, mux_Z;
  logic        busy, done;
  logic [31:0] result;

  logic [31:0] dp_r = '0, dp_z = '0;
  logic [63:0] dp_d = '0;
  logic        ge;

  typedef struct { logic [31:0] res; int cyc; } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic done_prev = 1'b0;

  m_div_ctrl dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
    .R(dp_r), .Z(dp_z), .mux_R(mux_R), .mux_D(mux_D), .mux_Z(mux_Z),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Restoring divider datapath: D starts at divisor<<31 and shifts right each step.
  assign ge = ({32'b0, dp_r} >= dp_d);
  always @(posedge clk) begin
    case (mux_R)
      R_A:     dp_r <= rs1;
      R_A_NEG: dp_r <= 32'(0 - rs1);
      R_SUB:   if (ge) dp_r <= dp_r - dp_d[31:0];
      default: ;
    endcase
    case (mux_D)
      D_B:     dp_d <= {1'b0, rs2, 31'b0};
      D_B_NEG: dp_d <= {1'b0, 32'(0 - rs2), 31'b0};
      D_SHR:   dp_d <= dp_d >> 1;
      default: ;
    endcase
    case (mux_Z)
      Z_ZERO:  dp_z <= '0;
      Z_SHL:   dp_z <= {dp_z[30:0], ge};
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    logic is_rem, sgn;
    is_rem = o[1];
    sgn    = ~o[0];
    if (b == 0) return is_rem ? a : 32'hFFFF_FFFF;
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_rem ? 32'h0 : 32'h8000_0000;
      return is_rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    end
    return is_rem ? a % b : a / b;
  endfunction

  function automatic bit is_special(input logic [1:0] o, input logic [31:0] a,
                                    input logic [31:0] b);
    return (b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Scoreboard consumer: every done must match the oldest pending expectation.
  always @(negedge clk) begin
    done_prev <= done;
    if (resetn) begin
      if (done && done_prev) chk("done_consecutive", 32'(done), 32'd0);
      if (done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("result", result, e.res);
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  // Drive a request now; start drops at the next negedge (accept edge k is then behind us).
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    op = o; rs1 = a; rs2 = b; start = 1'b1;
    e.res = ref_res(o, a, b);
    e.cyc = cyc + 1 + (is_special(o, a, b) ? 0 : 34);
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    #1;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("done_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    issue(o, a, b);
    wait_idle();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_mux_R", 32'(mux_R), 32'(R_KEEP));
    chk("rst_mux_D", 32'(mux_D), 32'(D_KEEP));
    chk("rst_mux_Z", 32'(mux_Z), 32'(Z_KEEP));

    // DIVU 100/7 with per-cycle busy and mux-select checks.
    @(negedge clk);
    issue(DIVU, 32'd100, 32'd7);
    chk("load_mux_R", 32'(mux_R), 32'(R_A));
    chk("load_mux_D", 32'(mux_D), 32'(D_B));
    chk("load_mux_Z", 32'(mux_Z), 32'(Z_ZERO));
    for (int i = 0; i < 34; i++) begin
      chk("busy_inflight", 32'(busy), 32'd1);
      if (i == 1) begin
        chk("iter_mux_R", 32'(mux_R), 32'(R_SUB));
        chk("iter_mux_D", 32'(mux_D), 32'(D_SHR));
        chk("iter_mux_Z", 32'(mux_Z), 32'(Z_SHL));
      end
      if (i == 33) chk("fin_mux_R", 32'(mux_R), 32'(R_KEEP));
      @(negedge clk);
    end
    chk("busy_after_done", 32'(busy), 32'd0);
    wait_idle();

    run(REMU, 32'd100, 32'd7);
    run(DIV, 32'hFFFF_FF9C, 32'd7);
    run(REM, 32'hFFFF_FF9C, 32'd7);
    @(negedge clk);
    issue(DIV, 32'd100, 32'hFFFF_FFF9);
    chk("negb_load_mux_D", 32'(mux_D), 32'(D_B_NEG));
    wait_idle();
    @(negedge clk);
    issue(REM, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
    chk("nega_load_mux_R", 32'(mux_R), 32'(R_A_NEG));
    wait_idle();
    run(REM, 32'd100, 32'hFFFF_FFF9);

    // Special cases answered from IDLE.
    @(negedge clk);
    issue(DIVU, 32'd5, 32'd0);
    chk("dz_busy", 32'(busy), 32'd0);
    chk("dz_mux_R", 32'(mux_R), 32'(R_KEEP));
    chk("dz_mux_Z", 32'(mux_Z), 32'(Z_KEEP));
    wait_idle();
    run(REM, 32'h1234_5678, 32'd0);
    run(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run(REM, 32'h8000_0000, 32'hFFFF_FFFF);
    run(DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
    run(REM, 32'h8000_0000, 32'd3);

    // A start pulse during ITER must be ignored.
    @(negedge clk);
    issue(DIV, 32'd1000, 32'd7);
    repeat (5) @(negedge clk);
    op = REMU; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    // Back-to-back: second start driven in the done cycle of the first.
    @(negedge clk);
    issue(DIVU, 32'd1000, 32'd3);
    wait_idle();
    issue(REM, 32'hFFFF_FFF9, 32'd2);
    wait_idle();

    // Reset mid-operation.
    @(negedge clk);
    issue(DIVU, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    exp_q.delete();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_mux_R", 32'(mux_R), 32'(R_KEEP));
    chk("abort_mux_D", 32'(mux_D), 32'(D_KEEP));
    chk("abort_mux_Z", 32'(mux_Z), 32'(Z_KEEP));
    resetn = 1'b1;
    run(DIVU, 32'd9, 32'd3);

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
